// File: rtl/cell_access_ctrl.sv
// Read sequencer and single-port arbiter for one cell position RAM.
// Streams the count-prefixed particle list while yielding the port to motion-update writes.
module cell_access_ctrl #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned WR_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_particle_id,
  output logic                  out_last,
  output logic                  err_count,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned BURST_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT   = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [BURST_W-1:0]    BURST_LIMIT = BURST_W'(WR_BURST_MAX);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CNT_REQ  = 3'd1,
    CNT_WAIT = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [BURST_W-1:0]    burst;

  // Read-tag pipeline, aligned with the 2-cycle RAM read latency.
  logic                  t1_vld;
  logic                  t1_cnt;
  logic [ADDR_WIDTH-1:0] t1_addr;
  logic                  t2_vld;
  logic                  t2_cnt;
  logic [ADDR_WIDTH-1:0] t2_addr;

  logic                  reading;
  logic                  force_rd;
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] raw_count;

  // Port arbitration: writes win unless an in-flight stream has been starved too long.
  always_comb begin
    reading     = (state == CNT_REQ) || (state == STREAM);
    force_rd    = reading && (burst == BURST_LIMIT);
    wr_ack      = wr_req && !force_rd;
    rd_issue    = reading && !wr_ack;
    ram_wren    = wr_ack;
    ram_rden    = rd_issue;
    ram_data    = '0;
    ram_address = '0;
    raw_count   = ram_q[ADDR_WIDTH-1:0];
    if (wr_ack) begin
      ram_address = wr_addr;
      ram_data    = wr_data;
    end else if (rd_issue) begin
      ram_address = (state == CNT_REQ) ? '0 : issue_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      issue_addr      <= '0;
      burst           <= '0;
      t1_vld          <= 1'b0;
      t1_cnt          <= 1'b0;
      t1_addr         <= '0;
      t2_vld          <= 1'b0;
      t2_cnt          <= 1'b0;
      t2_addr         <= '0;
      rd_busy         <= 1'b0;
      rd_done         <= 1'b0;
      out_valid       <= 1'b0;
      out_pos         <= '0;
      out_particle_id <= '0;
      out_last        <= 1'b0;
      err_count       <= 1'b0;
    end else begin
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;

      t1_vld  <= rd_issue;
      t1_cnt  <= (state == CNT_REQ);
      t1_addr <= (state == CNT_REQ) ? '0 : issue_addr;
      t2_vld  <= t1_vld;
      t2_cnt  <= t1_cnt;
      t2_addr <= t1_addr;

      // Only particle tags surface on the output; the count tag is consumed by the FSM.
      if (t2_vld && !t2_cnt) begin
        out_valid       <= 1'b1;
        out_pos         <= ram_q;
        out_particle_id <= t2_addr;
        out_last        <= (t2_addr == count);
      end

      if (reading && wr_ack) begin
        burst <= burst + BURST_W'(1);
      end else begin
        burst <= '0;
      end

      case (state)
        IDLE: begin
          if (rd_start) begin
            state      <= CNT_REQ;
            rd_busy    <= 1'b1;
            err_count  <= 1'b0;
            count      <= '0;
            issue_addr <= ADDR_WIDTH'(1);
          end
        end
        CNT_REQ: begin
          if (rd_issue) begin
            state <= CNT_WAIT;
          end
        end
        CNT_WAIT: begin
          if (t2_vld && t2_cnt) begin
            if (raw_count > MAX_COUNT) begin
              count     <= MAX_COUNT;
              err_count <= 1'b1;
            end else begin
              count <= raw_count;
            end
            if (raw_count == '0) begin
              state   <= DONE;
              rd_done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (rd_issue) begin
            if (issue_addr == count) begin
              state <= DRAIN;
            end else begin
              issue_addr <= issue_addr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (!t1_vld && !t2_vld) begin
            state   <= DONE;
            rd_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_access_ctrl.sv
// Directed bench for cell_access_ctrl with a 2-cycle-latency behavioural RAM.
module tb_cell_access_ctrl;

  localparam int unsigned DW = 96;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_start;
  logic          rd_busy;
  logic          rd_done;
  logic          out_valid;
  logic [DW-1:0] out_pos;
  logic [AW-1:0] out_particle_id;
  logic          out_last;
  logic          err_count;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_rden;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] q_p1 = '0;

  logic          s_valid, s_last, s_busy, s_done, s_err, s_ack, s_rden, s_wren;
  logic [DW-1:0] s_pos;
  logic [AW-1:0] s_id, s_addr;

  cell_access_ctrl #(
    .DATA_WIDTH(96), .PARTICLE_NUM(220), .ADDR_WIDTH(8), .WR_BURST_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_busy(rd_busy), .rd_done(rd_done),
    .out_valid(out_valid), .out_pos(out_pos), .out_particle_id(out_particle_id),
    .out_last(out_last), .err_count(err_count), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .ram_address(ram_address), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) q_p1 <= mem[ram_address];
    ram_q <= q_p1;
  end

  always @(negedge clk) begin
    if (ram_rden && ram_wren) both_cnt <= both_cnt + 1;
  end

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] v;
    v = i[31:0];
    return {32'hC0DE_0000 | v, 32'hBEEF_0000 | v, 32'hFACE_0000 | v};
  endfunction

  task automatic load(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_a = a[AW-1:0]; ld_d = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // One clock cycle: drive this cycle's inputs, then sample every output.
  task automatic step(input logic start, input logic r, input logic wreq,
                      input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    @(posedge clk); #1;
    rd_start = start; rst = r; wr_req = wreq; wr_addr = waddr; wr_data = wdata;
    #1;
    s_valid = out_valid; s_pos = out_pos; s_id = out_particle_id; s_last = out_last;
    s_busy = rd_busy; s_done = rd_done; s_err = err_count; s_ack = wr_ack;
    s_rden = ram_rden; s_wren = ram_wren; s_addr = ram_address;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if ({s_valid, s_last, s_busy, s_done, s_err, s_ack, s_rden, s_wren} !== 8'h00) begin
      errors++; $display("FAIL reset_flags got %b exp 00000000",
                         {s_valid, s_last, s_busy, s_done, s_err, s_ack, s_rden, s_wren});
    end
    checks++;
    if (s_id !== 8'd0 || s_pos !== 96'd0) begin
      errors++; $display("FAIL reset_data got id=%h pos=%h exp 0", s_id, s_pos);
    end
    step(1'b0, 1'b0, 1'b1, 8'd250, pat(250));
    checks++;
    if ({s_ack, s_wren, s_rden} !== 3'b110 || s_addr !== 8'd250) begin
      errors++; $display("FAIL idle_write got ack/wren/rden=%b addr=%0d exp 110 addr=250",
                         {s_ack, s_wren, s_rden}, s_addr);
    end
  endtask

  task automatic test_basic(input string tag);
    logic ev;
    for (int c = 0; c <= 12; c++) begin
      step(c == 0, 1'b0, 1'b0, '0, '0);
      ev = (c >= 7 && c <= 9);
      checks++;
      if (s_valid !== ev) begin
        errors++; $display("FAIL %s_valid c=%0d got %b exp %b", tag, c, s_valid, ev);
      end
      if (ev) begin
        checks++;
        if (s_id !== AW'(c - 6) || s_pos !== pat(c - 6)) begin
          errors++; $display("FAIL %s_data c=%0d got id=%0d pos=%h exp id=%0d pos=%h",
                             tag, c, s_id, s_pos, c - 6, pat(c - 6));
        end
      end
      checks++;
      if (s_last !== (c == 9) || s_done !== (c == 10)) begin
        errors++; $display("FAIL %s_last_done c=%0d got %b%b exp %b%b", tag, c,
                           s_last, s_done, c == 9, c == 10);
      end
      checks++;
      if (s_busy !== (c >= 1 && c <= 10)) begin
        errors++; $display("FAIL %s_busy c=%0d got %b exp %b", tag, c, s_busy, c >= 1 && c <= 10);
      end
    end
  endtask

  task automatic test_zero_count();
    logic eb;
    load(0, 96'd0);
    for (int c = 0; c <= 10; c++) begin
      step(c == 0 || c == 5, 1'b0, 1'b0, '0, '0);
      eb = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      checks++;
      if (s_busy !== eb || s_done !== (c == 4 || c == 9) || s_valid !== 1'b0) begin
        errors++; $display("FAIL zero_cnt c=%0d got busy/done/valid=%b%b%b exp %b%b0", c,
                           s_busy, s_done, s_valid, eb, c == 4 || c == 9);
      end
    end
  endtask

  task automatic test_write_burst();
    int   k = 0;
    logic wq;
    logic ea;
    load(0, 96'd5);
    for (int c = 0; c <= 28; c++) begin
      wq = (c >= 4 && c <= 20);
      step(c == 0, 1'b0, wq, AW'(100 + c), pat(100 + c));
      ea = wq && !(c == 8 || c == 13 || c == 18);
      checks++;
      if (s_ack !== ea) begin
        errors++; $display("FAIL burst_ack c=%0d got %b exp %b", c, s_ack, ea);
      end
      checks++;
      if (s_valid !== (c == 11 || c == 16 || c == 21 || c == 24 || c == 25)) begin
        errors++; $display("FAIL burst_valid c=%0d got %b", c, s_valid);
      end
      if (s_valid) begin
        k++;
        checks++;
        if (s_id !== AW'(k) || s_pos !== pat(k)) begin
          errors++; $display("FAIL burst_data c=%0d got id=%0d pos=%h exp id=%0d", c, s_id, s_pos, k);
        end
      end
      checks++;
      if (s_last !== (c == 25) || s_done !== (c == 26)) begin
        errors++; $display("FAIL burst_last_done c=%0d got %b%b", c, s_last, s_done);
      end
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL burst_exclusive got %0d overlaps exp 0", both_cnt);
    end
  endtask

  task automatic test_count_clamp();
    int   nv = 0;
    int   bad = 0;
    int   last_id = -1;
    logic done_seen = 1'b0;
    logic err_at_done = 1'b0;
    load(0, 96'd250);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c < 400 && !done_seen; c++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      if (s_valid) begin
        nv++;
        if (s_id !== AW'(nv) || s_pos !== pat(nv)) bad++;
        if (s_last) last_id = int'(s_id);
      end
      if (s_done) begin
        done_seen = 1'b1;
        err_at_done = s_err;
      end
    end
    checks++;
    if (done_seen !== 1'b1) begin
      errors++; $display("FAIL clamp_timeout got no rd_done exp rd_done");
    end
    checks++;
    if (nv != 219 || bad != 0) begin
      errors++; $display("FAIL clamp_stream got %0d valids %0d bad exp 219 valids 0 bad", nv, bad);
    end
    checks++;
    if (last_id != 219 || err_at_done !== 1'b1) begin
      errors++; $display("FAIL clamp_last_err got last=%0d err=%b exp last=219 err=1",
                         last_id, err_at_done);
    end
    load(0, 96'd0);
    checks++;
    if (err_count !== 1'b1) begin
      errors++; $display("FAIL clamp_sticky got %b exp 1", err_count);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (s_err !== 1'b0) begin
      errors++; $display("FAIL clamp_clear got %b exp 0", s_err);
    end
    for (int c = 2; c <= 5; c++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_stream();
    load(0, 96'd3);
    for (int c = 0; c <= 8; c++) begin
      step(c == 0, c == 8, 1'b0, '0, '0);
    end
    checks++;
    if (s_valid !== 1'b1 || s_id !== 8'd2) begin
      errors++; $display("FAIL rstmid_pre got valid=%b id=%0d exp valid=1 id=2", s_valid, s_id);
    end
    for (int c = 9; c <= 15; c++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      checks++;
      if ({s_valid, s_last, s_busy, s_done, s_err, s_rden, s_wren} !== 7'h00 ||
          s_id !== 8'd0 || s_pos !== 96'd0) begin
        errors++; $display("FAIL rstmid_quiet c=%0d got flags=%b id=%0d pos=%h exp 0", c,
                           {s_valid, s_last, s_busy, s_done, s_err, s_rden, s_wren}, s_id, s_pos);
      end
    end
    test_basic("rstmid_rerun");
  endtask

  task automatic test_write_coherence();
    logic          ev;
    logic [DW-1:0] newd = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
    logic [DW-1:0] epos;
    for (int c = 0; c <= 13; c++) begin
      step(c == 0, 1'b0, c == 4, 8'd2, newd);
      if (c == 4) begin
        checks++;
        if (s_ack !== 1'b1 || s_rden !== 1'b0) begin
          errors++; $display("FAIL coh_ack got ack=%b rden=%b exp 1 0", s_ack, s_rden);
        end
      end
      ev = (c >= 8 && c <= 10);
      checks++;
      if (s_valid !== ev) begin
        errors++; $display("FAIL coh_valid c=%0d got %b exp %b", c, s_valid, ev);
      end
      if (ev) begin
        epos = (c == 9) ? newd : pat(c - 7);
        checks++;
        if (s_id !== AW'(c - 7) || s_pos !== epos) begin
          errors++; $display("FAIL coh_data c=%0d got id=%0d pos=%h exp id=%0d pos=%h",
                             c, s_id, s_pos, c - 7, epos);
        end
      end
      checks++;
      if (s_last !== (c == 10) || s_done !== (c == 11) || s_busy !== (c >= 1 && c <= 11)) begin
        errors++; $display("FAIL coh_ctrl c=%0d got last/done/busy=%b%b%b", c, s_last, s_done, s_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rd_start = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    for (int i = 1; i < 256; i++) load(i, pat(i));
    load(0, 96'd3);
    test_basic("basic");
    test_zero_count();
    test_write_burst();
    test_count_clamp();
    test_reset_mid_stream();
    test_write_coherence();
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL port_exclusive got %0d overlaps exp 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
